// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART receiver.
package uart_pkg;

    // Receiver FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WRITE,
        ST_WAIT
    } uart_state_t;

    // Parity modes
    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_ODD  = 2'd1;
    localparam logic [1:0] PARITY_EVEN = 2'd2;

    // Clock cycles per bit on the line (integer division)
    function automatic logic [31:0] clks_per_bit(input logic [31:0] clock_frequency,
                                                 input logic [31:0] baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module uart_sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] stage_reg;

    // Shift the raw input through two flops; both come out of reset at RESET_VALUE
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_reg <= {2{RESET_VALUE}};
        end else begin
            stage_reg <= {stage_reg[0], d};
        end
    end

    assign q = stage_reg[1];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: mid-bit sampling, configurable word width, parity and stop bits,
// with framing/parity/overrun reporting towards a downstream FIFO write port.
module uart_receiver
    import uart_pkg::*;
#(
    parameter logic [31:0] CLOCK_FREQUENCY = 32'd100_000_000,
    parameter logic [31:0] BAUD_RATE       = 32'd115200,
    parameter logic [31:0] WORD_WIDTH      = 32'd8,
    parameter logic [1:0]  PARITY          = 2'd0,
    parameter logic [31:0] STOP_BITS       = 32'd1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din,
    input  logic                  full,
    output logic [WORD_WIDTH-1:0] dout,
    output logic                  we,
    output logic                  parity_error,
    output logic                  frame_error,
    output logic                  overrun
);

    localparam logic [31:0] C  = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam logic [31:0] H  = C / 2;
    localparam int          CW = (C > 1) ? $clog2(C) : 1;

    localparam logic [CW-1:0] C_LAST    = CW'(C - 1);
    localparam logic [CW-1:0] H_LAST    = CW'(H - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(WORD_WIDTH - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    // Refuse to build with an unusable configuration
    if (BAUD_RATE == 0 || C < 4 || WORD_WIDTH < 5 || WORD_WIDTH > 9 ||
        PARITY > PARITY_EVEN || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
        $error("uart_receiver: illegal parameter combination");
    end

    logic ds;

    uart_sync_2ff #(
        .RESET_VALUE(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (din),
        .q  (ds)
    );

    uart_state_t           state_reg, state_next;
    logic [CW-1:0]         baud_cnt_reg, baud_cnt_next;
    logic [3:0]            bit_cnt_reg, bit_cnt_next;
    logic [WORD_WIDTH-1:0] shift_reg, shift_next;
    logic                  perr_reg, perr_next;
    logic                  ferr_reg, ferr_next;
    logic [WORD_WIDTH-1:0] dout_reg, dout_next;
    logic                  parity_error_reg, parity_error_next;
    logic                  frame_error_reg, frame_error_next;

    logic baud_tick;
    logic start_tick;

    assign baud_tick  = (baud_cnt_reg == C_LAST);
    assign start_tick = (baud_cnt_reg == H_LAST);

    // Next-state, datapath updates and the write/overrun strobes
    always_comb begin
        state_next        = state_reg;
        baud_cnt_next     = baud_cnt_reg;
        bit_cnt_next      = bit_cnt_reg;
        shift_next        = shift_reg;
        perr_next         = perr_reg;
        ferr_next         = ferr_reg;
        dout_next         = dout_reg;
        parity_error_next = parity_error_reg;
        frame_error_next  = frame_error_reg;
        we                = 1'b0;
        overrun           = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                baud_cnt_next = '0;
                bit_cnt_next  = '0;
                perr_next     = 1'b0;
                ferr_next     = 1'b0;
                if (!ds) begin
                    state_next = ST_START;
                end
            end

            ST_START: begin
                if (start_tick) begin
                    baud_cnt_next = '0;
                    state_next    = ds ? ST_IDLE : ST_DATA;
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end

            ST_DATA: begin
                if (baud_tick) begin
                    baud_cnt_next = '0;
                    shift_next    = {ds, shift_reg[WORD_WIDTH-1:1]};
                    if (bit_cnt_reg == BIT_LAST) begin
                        bit_cnt_next = '0;
                        state_next   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end

            ST_PARITY: begin
                if (baud_tick) begin
                    baud_cnt_next = '0;
                    perr_next     = (PARITY == PARITY_ODD) ? ~(^shift_reg ^ ds)
                                                           :  (^shift_reg ^ ds);
                    state_next    = ST_STOP;
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end

            ST_STOP: begin
                if (baud_tick) begin
                    baud_cnt_next = '0;
                    if (!ds) begin
                        ferr_next = 1'b1;
                    end
                    if (bit_cnt_reg == STOP_LAST) begin
                        bit_cnt_next      = '0;
                        state_next        = ST_WRITE;
                        dout_next         = shift_reg;
                        parity_error_next = perr_reg;
                        frame_error_next  = ferr_reg | ~ds;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end

            ST_WRITE: begin
                // A reset landing in this cycle cancels the write
                we         = ~full & ~rst;
                overrun    =  full & ~rst;
                state_next = ST_WAIT;
            end

            ST_WAIT: begin
                // Stay here while the line is low so a break never looks like a start bit
                if (ds) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_WAIT;
            end
        endcase
    end

    // State and datapath registers; reset parks the FSM in WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_WAIT;
            baud_cnt_reg     <= '0;
            bit_cnt_reg      <= '0;
            shift_reg        <= '0;
            perr_reg         <= 1'b0;
            ferr_reg         <= 1'b0;
            dout_reg         <= '0;
            parity_error_reg <= 1'b0;
            frame_error_reg  <= 1'b0;
        end else begin
            state_reg        <= state_next;
            baud_cnt_reg     <= baud_cnt_next;
            bit_cnt_reg      <= bit_cnt_next;
            shift_reg        <= shift_next;
            perr_reg         <= perr_next;
            ferr_reg         <= ferr_next;
            dout_reg         <= dout_next;
            parity_error_reg <= parity_error_next;
            frame_error_reg  <= frame_error_next;
        end
    end

    assign dout         = dout_reg;
    assign parity_error = parity_error_reg;
    assign frame_error  = frame_error_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: default 8N1 instance and an 8E2 instance.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int C  = 868;
    localparam int H  = 434;
    localparam int L0 = 8248;
    localparam int L1 = 9984;

    logic       clk = 1'b0;
    logic       rst0, rst1, din0, din1, full0, full1;
    logic [7:0] dout0, dout1;
    logic       we0, we1, pe0, pe1, fe0, fe1, ov0, ov1;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    int         we0_cnt = 0, we0_at = 0, ov0_cnt = 0, ov0_at = 0;
    int         we1_cnt = 0, we1_at = 0, ov1_cnt = 0;
    logic [7:0] dout0_cap = '0, dout1_cap = '0;
    logic       pe0_cap = 1'b0, fe0_cap = 1'b0, pe1_cap = 1'b0, fe1_cap = 1'b0;

    uart_receiver dut0 (
        .clk(clk), .rst(rst0), .din(din0), .full(full0), .dout(dout0), .we(we0),
        .parity_error(pe0), .frame_error(fe0), .overrun(ov0)
    );

    uart_receiver #(
        .PARITY(2'd2), .STOP_BITS(32'd2)
    ) dut1 (
        .clk(clk), .rst(rst1), .din(din1), .full(full1), .dout(dout1), .we(we1),
        .parity_error(pe1), .frame_error(fe1), .overrun(ov1)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge number E, cyc == E
    always @(posedge clk) cyc <= cyc + 1;

    // Capture write/overrun strobes away from the active edge
    always @(negedge clk) begin
        if (we0) begin
            we0_cnt   <= we0_cnt + 1;
            we0_at    <= cyc;
            dout0_cap <= dout0;
            pe0_cap   <= pe0;
            fe0_cap   <= fe0;
            $display("[TB] dut0 write dout=%02h pe=%0b fe=%0b at edge %0d", dout0, pe0, fe0, cyc);
        end
        if (ov0) begin
            ov0_cnt <= ov0_cnt + 1;
            ov0_at  <= cyc;
            $display("[TB] dut0 overrun at edge %0d", cyc);
        end
        if (we1) begin
            we1_cnt   <= we1_cnt + 1;
            we1_at    <= cyc;
            dout1_cap <= dout1;
            pe1_cap   <= pe1;
            fe1_cap   <= fe1;
            $display("[TB] dut1 write dout=%02h pe=%0b fe=%0b at edge %0d", dout1, pe1, fe1, cyc);
        end
        if (ov1) ov1_cnt <= ov1_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_din(input int inst, input logic v);
        if (inst == 0) din0 = v;
        else           din1 = v;
    endtask

    // Drives one frame starting at a negedge; t0 is the edge-0 number of the frame
    task automatic send_frame(input int inst, input logic [7:0] data, input bit has_par,
                              input logic par, input int nstop, input logic [1:0] stop_v,
                              output int t0);
        set_din(inst, 1'b0);
        t0 = cyc + 1;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_din(inst, data[i]);
            repeat (C) @(negedge clk);
        end
        if (has_par) begin
            set_din(inst, par);
            repeat (C) @(negedge clk);
        end
        for (int s = 0; s < nstop; s++) begin
            set_din(inst, stop_v[s]);
            repeat (C) @(negedge clk);
        end
    endtask

    initial begin
        int t;
        int u;
        logic [7:0] a5;
        a5 = 8'hA5;
        din0 = 1'b1; din1 = 1'b1; full0 = 1'b0; full1 = 1'b0;
        rst0 = 1'b1; rst1 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_we0", {31'd0, we0}, 32'd0);
        check("rst_ov0", {31'd0, ov0}, 32'd0);
        check("rst_dout0", {24'd0, dout0}, 32'd0);
        check("rst_flags0", {30'd0, pe0, fe0}, 32'd0);
        check("rst_state0", 32'(dut0.state_reg), 32'(ST_WAIT));
        check("rst_we1", {31'd0, we1}, 32'd0);
        rst0 = 1'b0; rst1 = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_after_rst0", 32'(dut0.state_reg), 32'(ST_IDLE));

        fork
            begin
                // 8N1: clean frame
                send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 2'b11, t);
                repeat (10) @(negedge clk);
                check("a5_we_count", we0_cnt, 1);
                check("a5_we_edge", we0_at - t, L0);
                check("a5_dout", {24'd0, dout0_cap}, 32'hA5);
                check("a5_flags", {30'd0, pe0_cap, fe0_cap}, 32'd0);
                check("a5_we_low", {31'd0, we0}, 32'd0);
                check("a5_dout_hold", {24'd0, dout0}, 32'hA5);

                // Stop bit low, line held low afterwards
                send_frame(0, 8'h5A, 1'b0, 1'b0, 1, 2'b00, t);
                repeat (3 * C) @(negedge clk);
                check("brk_we_count", we0_cnt, 2);
                check("brk_we_edge", we0_at - t, L0);
                check("brk_dout", {24'd0, dout0_cap}, 32'h5A);
                check("brk_fe", {31'd0, fe0_cap}, 32'd1);
                check("brk_state_wait", 32'(dut0.state_reg), 32'(ST_WAIT));
                din0 = 1'b1;
                repeat (C) @(negedge clk);
                check("brk_no_new_we", we0_cnt, 2);
                check("brk_idle", 32'(dut0.state_reg), 32'(ST_IDLE));

                // Short glitch rejected at the mid-start sample
                din0 = 1'b0;
                repeat (H - 10) @(negedge clk);
                din0 = 1'b1;
                repeat (C) @(negedge clk);
                check("glitch_no_we", we0_cnt, 2);
                check("glitch_idle", 32'(dut0.state_reg), 32'(ST_IDLE));

                send_frame(0, 8'h81, 1'b0, 1'b0, 1, 2'b11, t);
                repeat (10) @(negedge clk);
                check("x81_we_count", we0_cnt, 3);
                check("x81_we_edge", we0_at - t, L0);
                check("x81_dout", {24'd0, dout0_cap}, 32'h81);
                check("x81_fe", {31'd0, fe0_cap}, 32'd0);

                // Downstream full: frame dropped with overrun
                full0 = 1'b1;
                send_frame(0, 8'hFF, 1'b0, 1'b0, 1, 2'b11, t);
                repeat (10) @(negedge clk);
                full0 = 1'b0;
                check("ovr_no_we", we0_cnt, 3);
                check("ovr_count", ov0_cnt, 1);
                check("ovr_edge", ov0_at - t, L0);

                send_frame(0, 8'h00, 1'b0, 1'b0, 1, 2'b11, t);
                repeat (10) @(negedge clk);
                check("x00_we_count", we0_cnt, 4);
                check("x00_we_edge", we0_at - t, L0);
                check("x00_dout", {24'd0, dout0_cap}, 32'h00);
                check("x00_ov_once", ov0_cnt, 1);

                // Reset in the middle of data bit 4
                din0 = 1'b0;
                repeat (C) @(negedge clk);
                for (int i = 0; i < 4; i++) begin
                    din0 = a5[i];
                    repeat (C) @(negedge clk);
                end
                din0 = a5[4];
                repeat (H) @(negedge clk);
                rst0 = 1'b1;
                repeat (2) @(negedge clk);
                rst0 = 1'b0;
                check("midrst_dout_cleared", {24'd0, dout0}, 32'd0);
                repeat (100) @(negedge clk);
                din0 = 1'b1;
                repeat (2 * C) @(negedge clk);
                check("midrst_no_we", we0_cnt, 4);

                send_frame(0, 8'h12, 1'b0, 1'b0, 1, 2'b11, t);
                repeat (10) @(negedge clk);
                check("x12_we_count", we0_cnt, 5);
                check("x12_we_edge", we0_at - t, L0);
                check("x12_dout", {24'd0, dout0_cap}, 32'h12);
            end
            begin
                // 8E2: correct parity
                send_frame(1, 8'h3C, 1'b1, 1'b0, 2, 2'b11, u);
                repeat (10) @(negedge clk);
                check("e2_we_count", we1_cnt, 1);
                check("e2_we_edge", we1_at - u, L1);
                check("e2_dout", {24'd0, dout1_cap}, 32'h3C);
                check("e2_flags", {30'd0, pe1_cap, fe1_cap}, 32'd0);

                // Wrong parity bit
                send_frame(1, 8'h3C, 1'b1, 1'b1, 2, 2'b11, u);
                repeat (10) @(negedge clk);
                check("e2_bad_we_count", we1_cnt, 2);
                check("e2_bad_pe", {31'd0, pe1_cap}, 32'd1);
                check("e2_bad_fe", {31'd0, fe1_cap}, 32'd0);

                // Correct parity, first of two stop bits low
                send_frame(1, 8'h01, 1'b1, 1'b1, 2, 2'b10, u);
                repeat (10) @(negedge clk);
                check("e2_stop1_we_count", we1_cnt, 3);
                check("e2_stop1_dout", {24'd0, dout1_cap}, 32'h01);
                check("e2_stop1_flags", {30'd0, pe1_cap, fe1_cap}, 32'd1);
                check("e2_no_overrun", ov1_cnt, 0);
            end
        join

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
